// File: rtl/soc_bus_fabric_if.sv
// soc_bus_fabric_if
// Bundles the picorv32 native memory port (m_*) and the shared/per-slave
// peripheral bus (s_*) handled by soc_bus_fabric.
//
// Modports:
//   slave  - the fabric's view. It is the slave of the CPU port and drives
//            the peripheral request signals.
//   master - the environment's view. The CPU drives m_valid/m_addr/m_wdata/
//            m_wstrb, and the peripherals drive s_ready/s_rdata.
//
// Signals:
//   m_valid, m_addr[31:0], m_wdata[31:0], m_wstrb[3:0]   CPU request
//   m_ready, m_rdata[31:0]                               CPU completion
//   s_valid[NUM_SLAVES], s_addr, s_wdata, s_wstrb        peripheral request
//   s_ready[NUM_SLAVES], s_rdata[32*NUM_SLAVES]          peripheral response
interface soc_bus_fabric_if #(
  parameter int NUM_SLAVES = 4
) ();
  logic                    m_valid;
  logic [31:0]             m_addr;
  logic [31:0]             m_wdata;
  logic [3:0]              m_wstrb;
  logic                    m_ready;
  logic [31:0]             m_rdata;

  logic [NUM_SLAVES-1:0]   s_valid;
  logic [31:0]             s_addr;
  logic [31:0]             s_wdata;
  logic [3:0]              s_wstrb;
  logic [NUM_SLAVES-1:0]   s_ready;
  logic [32*NUM_SLAVES-1:0] s_rdata;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric
// Interconnect between the picorv32 native memory port and up to NUM_SLAVES
// peripherals. Slave i is selected when m_addr[31:24] equals
// SLAVE_BASE[8*i+:8]; on overlapping entries the lowest index wins. Each
// slave has its own valid/ready handshake, so it may insert wait states.
// Unmapped accesses are answered with ERR_DATA and logged in a sticky
// error flag plus the offending address.
//
// Build option:
//   BUS_TIMEOUT_EN  when defined, an access whose slave does not answer
//                   within TIMEOUT_CYCLES cycles is forcibly terminated
//                   with ERR_DATA and logged like an unmapped access.
//                   When undefined the fabric waits for s_ready forever.
//
// Ports:
//   clk_cpu    clock, rising edge
//   n_reset    asynchronous active-low reset
//   bus        soc_bus_fabric_if.slave (CPU port + peripheral bus)
//   err_clear  clears bus_err (a simultaneous new error takes priority)
//   bus_err    sticky error flag
//   err_addr   address of the most recent errored access
module soc_bus_fabric #(
  parameter int                    NUM_SLAVES     = 4,
  parameter logic [8*NUM_SLAVES-1:0] SLAVE_BASE   = (8*NUM_SLAVES)'(32'hFF_FE_01_00),
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [31:0]           ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic               clk_cpu,
  input  logic               n_reset,
  soc_bus_fabric_if.slave    bus,
  input  logic               err_clear,
  output logic               bus_err,
  output logic [31:0]        err_addr
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                state_reg, state_next;
  logic [NUM_SLAVES-1:0] s_valid_reg, s_valid_next;
  logic [31:0]           s_addr_reg, s_addr_next;
  logic [31:0]           s_wdata_reg, s_wdata_next;
  logic [3:0]            s_wstrb_reg, s_wstrb_next;
  logic [31:0]           m_rdata_reg, m_rdata_next;
  logic                  m_ready_reg, m_ready_next;
  logic                  bus_err_reg, bus_err_next;
  logic [31:0]           err_addr_reg, err_addr_next;

  logic [NUM_SLAVES-1:0] match;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic [31:0]           slave_rdata [NUM_SLAVES];
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  timeout_hit;

  // Address decode and per-slave read-data slices
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign match[gi]       = (bus.m_addr[31:24] == SLAVE_BASE[8*gi +: 8]);
      assign slave_rdata[gi] = bus.s_rdata[32*gi +: 32];
    end
  endgenerate

  // Isolate the lowest set bit so overlapping windows resolve to the
  // lowest slave index.
  assign sel_onehot = match & (~match + NUM_SLAVES'(1));

  // While in ACCESS, s_valid_reg is the one-hot select of the active slave;
  // only that slave's ready/data can influence the FSM.
  always_comb begin
    sel_ready = |(bus.s_ready & s_valid_reg);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_valid_reg[i]) begin
        sel_rdata = sel_rdata | slave_rdata[i];
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] cnt_inc;

  assign cnt_inc = cnt_reg + 16'd1;
  // Terminating when the incremented count reaches the limit keeps s_valid
  // high for exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (state_reg == ACCESS) && !sel_ready &&
                       (cnt_inc == 16'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg != ACCESS) begin
      cnt_next = '0;
    end else if (!sel_ready) begin
      cnt_next = cnt_inc;
    end
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state and output logic
  always_comb begin
    state_next    = state_reg;
    s_valid_next  = s_valid_reg;
    s_addr_next   = s_addr_reg;
    s_wdata_next  = s_wdata_reg;
    s_wstrb_next  = s_wstrb_reg;
    m_rdata_next  = m_rdata_reg;
    m_ready_next  = 1'b0;
    bus_err_next  = bus_err_reg & ~err_clear;
    err_addr_next = err_addr_reg;

    case (state_reg)
      IDLE: begin
        // m_ready_reg is high in the idle cycle right after RESP, while
        // picorv32 still holds m_valid for the finished access; ignore it.
        if (bus.m_valid && !m_ready_reg) begin
          if (|match) begin
            s_addr_next  = bus.m_addr;
            s_wdata_next = bus.m_wdata;
            s_wstrb_next = bus.m_wstrb;
            s_valid_next = sel_onehot;
            state_next   = ACCESS;
          end else begin
            m_rdata_next  = ERR_DATA;
            bus_err_next  = 1'b1;
            err_addr_next = bus.m_addr;
            state_next    = RESP;
          end
        end
      end

      ACCESS: begin
        if (sel_ready) begin
          m_rdata_next = sel_rdata;
          s_valid_next = '0;
          state_next   = RESP;
        end else if (timeout_hit) begin
          m_rdata_next  = ERR_DATA;
          s_valid_next  = '0;
          bus_err_next  = 1'b1;
          err_addr_next = s_addr_reg;
          state_next    = RESP;
        end
      end

      RESP: begin
        m_ready_next = 1'b1;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= IDLE;
      s_valid_reg  <= '0;
      s_addr_reg   <= '0;
      s_wdata_reg  <= '0;
      s_wstrb_reg  <= '0;
      m_rdata_reg  <= '0;
      m_ready_reg  <= 1'b0;
      bus_err_reg  <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      s_valid_reg  <= s_valid_next;
      s_addr_reg   <= s_addr_next;
      s_wdata_reg  <= s_wdata_next;
      s_wstrb_reg  <= s_wstrb_next;
      m_rdata_reg  <= m_rdata_next;
      m_ready_reg  <= m_ready_next;
      bus_err_reg  <= bus_err_next;
      err_addr_reg <= err_addr_next;
    end
  end

  assign bus.s_valid = s_valid_reg;
  assign bus.s_addr  = s_addr_reg;
  assign bus.s_wdata = s_wdata_reg;
  assign bus.s_wstrb = s_wstrb_reg;
  assign bus.m_rdata = m_rdata_reg;
  assign bus.m_ready = m_ready_reg;
  assign bus_err     = bus_err_reg;
  assign err_addr    = err_addr_reg;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// tb_soc_bus_fabric
// Directed bench for soc_bus_fabric. u_dut uses the default address map
// (slave0=0x00, slave1=0x01, slave2=0xFE, slave3=0xFF) with
// TIMEOUT_CYCLES=8; u_ovl uses SLAVE_BASE=32'h01010101 to exercise
// overlapping windows. The timeout scenario runs when BUS_TIMEOUT_EN is
// defined.
module tb_soc_bus_fabric;

  logic        clk_cpu;
  logic        n_reset;
  logic        err_clear;
  logic        bus_err;
  logic [31:0] err_addr;
  logic        ovl_err_clear;
  logic        ovl_bus_err;
  logic [31:0] ovl_err_addr;

  int total;
  int bad;

  soc_bus_fabric_if #(.NUM_SLAVES(4)) bus ();
  soc_bus_fabric_if #(.NUM_SLAVES(4)) ovl_bus ();

  soc_bus_fabric #(
    .NUM_SLAVES     (4),
    .SLAVE_BASE     (32'hFF_FE_01_00),
    .TIMEOUT_CYCLES (8),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) u_dut (
    .clk_cpu   (clk_cpu),
    .n_reset   (n_reset),
    .bus       (bus),
    .err_clear (err_clear),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  soc_bus_fabric #(
    .NUM_SLAVES     (4),
    .SLAVE_BASE     (32'h01_01_01_01),
    .TIMEOUT_CYCLES (8),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) u_ovl (
    .clk_cpu   (clk_cpu),
    .n_reset   (n_reset),
    .bus       (ovl_bus),
    .err_clear (ovl_err_clear),
    .bus_err   (ovl_bus_err),
    .err_addr  (ovl_err_addr)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  // Behavioural slaves for u_dut: slave i raises s_ready after wait_cfg[i]
  // wait cycles (-1 = never). stray drives s_ready of idle slaves high.
  int          wait_cfg [4];
  int          wait_cnt [4];
  logic [31:0] data_cfg [4];
  bit          stray;

  assign bus.s_rdata = {data_cfg[3], data_cfg[2], data_cfg[1], data_cfg[0]};

  always @(negedge clk_cpu) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.s_valid[i]) begin
        bus.s_ready[i] = (wait_cnt[i] == wait_cfg[i]);
        wait_cnt[i]++;
      end else begin
        bus.s_ready[i] = stray;
        wait_cnt[i]    = 0;
      end
    end
  end

  // Zero-wait slaves for u_ovl, each returning a distinct word
  assign ovl_bus.s_ready = ovl_bus.s_valid;
  assign ovl_bus.s_rdata = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One CPU transaction on u_dut. exp_lat counts edges from the edge that
  // samples m_valid to the edge after which m_ready is high.
  task automatic run_txn(input string tag, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input bit clr, input bit drop,
                         input int exp_lat, input logic [3:0] exp_sel,
                         input int exp_sv, input logic [31:0] exp_rdata);
    int          lat;
    int          sv;
    int          hold;
    logic [3:0]  seen;
    logic [31:0] rd;
    lat  = 0;
    sv   = 0;
    hold = 0;
    seen = '0;
    @(negedge clk_cpu);
    bus.m_valid = 1'b1;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_wstrb = wstrb;
    err_clear   = clr;
    while (lat < 200) begin
      @(posedge clk_cpu);
      #1;
      lat++;
      err_clear = 1'b0;
      if (drop) bus.m_valid = 1'b0;
      if (bus.s_valid != 4'b0) begin
        sv++;
        seen = seen | bus.s_valid;
        if (bus.s_addr == addr && bus.s_wdata == wdata && bus.s_wstrb == wstrb) hold++;
      end
      if (bus.m_ready) break;
    end
    rd = bus.m_rdata;
    // m_valid is still high here, as picorv32 would leave it
    @(posedge clk_cpu);
    #1;
    chk({tag, ":pulse"}, {31'b0, bus.m_ready}, 32'd0);
    chk({tag, ":no_reissue"}, {28'b0, bus.s_valid}, 32'd0);
    bus.m_valid = 1'b0;
    bus.m_wstrb = 4'b0;
    chk({tag, ":latency"}, lat - 1, exp_lat);
    chk({tag, ":sel"}, {28'b0, seen}, {28'b0, exp_sel});
    chk({tag, ":svalid_cycles"}, sv, exp_sv);
    chk({tag, ":held_cycles"}, hold, exp_sv);
    chk({tag, ":rdata"}, rd, exp_rdata);
  endtask

  task automatic ovl_test();
    int          lat;
    logic [3:0]  seen;
    lat  = 0;
    seen = '0;
    @(negedge clk_cpu);
    ovl_bus.m_valid = 1'b1;
    ovl_bus.m_addr  = 32'h01AB_CDEF;
    ovl_bus.m_wdata = 32'h0;
    ovl_bus.m_wstrb = 4'b0;
    while (lat < 20) begin
      @(posedge clk_cpu);
      #1;
      lat++;
      seen = seen | ovl_bus.s_valid;
      if (ovl_bus.m_ready) break;
    end
    chk("ovl:sel", {28'b0, seen}, 32'h1);
    chk("ovl:rdata", ovl_bus.m_rdata, 32'hA000_0000);
    chk("ovl:latency", lat - 1, 32'd2);
    chk("ovl:bus_err", {31'b0, ovl_bus_err}, 32'd0);
    @(posedge clk_cpu);
    #1;
    ovl_bus.m_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_reset       = 1'b0;
    err_clear     = 1'b0;
    ovl_err_clear = 1'b0;
    stray         = 1'b0;
    bus.m_valid   = 1'b0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.m_wstrb   = '0;
    bus.s_ready   = '0;
    ovl_bus.m_valid = 1'b0;
    ovl_bus.m_addr  = '0;
    ovl_bus.m_wdata = '0;
    ovl_bus.m_wstrb = '0;
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 0;
      wait_cnt[i] = 0;
      data_cfg[i] = 32'h0;
    end

    // Reset state
    repeat (3) @(posedge clk_cpu);
    #1;
    chk("rst:m_ready", {31'b0, bus.m_ready}, 32'd0);
    chk("rst:m_rdata", bus.m_rdata, 32'h0);
    chk("rst:s_valid", {28'b0, bus.s_valid}, 32'h0);
    chk("rst:s_addr", bus.s_addr, 32'h0);
    chk("rst:s_wdata", bus.s_wdata, 32'h0);
    chk("rst:s_wstrb", {28'b0, bus.s_wstrb}, 32'h0);
    chk("rst:bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst:err_addr", err_addr, 32'h0);
    @(negedge clk_cpu);
    n_reset = 1'b1;

    // Zero-wait read from slave 1
    data_cfg[1] = 32'h1234_5678;
    run_txn("rd_s1", 32'h0100_0010, 32'h0, 4'b0000, 1'b0, 1'b0, 2, 4'b0010, 1, 32'h1234_5678);

    // Byte write to slave 3 with five wait cycles
    wait_cfg[3] = 5;
    data_cfg[3] = 32'h0000_3333;
    run_txn("wr_s3", 32'hFF00_0000, 32'h0000_0041, 4'b0001, 1'b0, 1'b0, 7, 4'b1000, 6, 32'h0000_3333);
    chk("wr_s3:bus_err", {31'b0, bus_err}, 32'd0);

    // Unmapped read
    run_txn("unmapped", 32'h8000_0000, 32'h0, 4'b0000, 1'b0, 1'b0, 1, 4'b0000, 0, 32'hDEAD_BEEF);
    chk("unmapped:bus_err", {31'b0, bus_err}, 32'd1);
    chk("unmapped:err_addr", err_addr, 32'h8000_0000);

    // err_clear pulse
    @(negedge clk_cpu);
    err_clear = 1'b1;
    @(posedge clk_cpu);
    #1;
    err_clear = 1'b0;
    chk("clear:bus_err", {31'b0, bus_err}, 32'd0);
    chk("clear:err_addr", err_addr, 32'h8000_0000);

    // err_clear in the same cycle as a new error: the error wins
    run_txn("clr_vs_err", 32'h7F00_0123, 32'h0, 4'b0000, 1'b1, 1'b0, 1, 4'b0000, 0, 32'hDEAD_BEEF);
    chk("clr_vs_err:bus_err", {31'b0, bus_err}, 32'd1);
    chk("clr_vs_err:err_addr", err_addr, 32'h7F00_0123);

    // Slave 2 with two waits while idle slaves hold s_ready high
    stray       = 1'b1;
    wait_cfg[2] = 2;
    data_cfg[2] = 32'hCAFE_F00D;
    run_txn("stray_rdy", 32'hFE00_0020, 32'h0, 4'b0000, 1'b0, 1'b0, 4, 4'b0100, 3, 32'hCAFE_F00D);
    stray = 1'b0;

    // m_valid dropped right after acceptance still completes
    wait_cfg[1] = 3;
    data_cfg[1] = 32'h55AA_55AA;
    run_txn("mvalid_drop", 32'h0100_0100, 32'h0, 4'b0000, 1'b0, 1'b1, 5, 4'b0010, 4, 32'h55AA_55AA);

`ifdef BUS_TIMEOUT_EN
    // Slave 2 never answers
    @(negedge clk_cpu);
    err_clear = 1'b1;
    @(negedge clk_cpu);
    err_clear   = 1'b0;
    wait_cfg[2] = -1;
    run_txn("timeout", 32'hFE00_0000, 32'h0, 4'b0000, 1'b0, 1'b0, 9, 4'b0100, 8, 32'hDEAD_BEEF);
    chk("timeout:bus_err", {31'b0, bus_err}, 32'd1);
    chk("timeout:err_addr", err_addr, 32'hFE00_0000);
    @(negedge clk_cpu);
    err_clear = 1'b1;
    @(posedge clk_cpu);
    #1;
    err_clear = 1'b0;
    chk("timeout:cleared", {31'b0, bus_err}, 32'd0);
    wait_cfg[2] = 0;
`endif

    // Reset asserted while slave 0 is in ACCESS
    wait_cfg[0] = 10;
    @(negedge clk_cpu);
    bus.m_valid = 1'b1;
    bus.m_addr  = 32'h0000_0008;
    bus.m_wdata = 32'h0;
    bus.m_wstrb = 4'b0;
    @(posedge clk_cpu);
    #1;
    chk("abort:s_valid_before", {28'b0, bus.s_valid}, 32'h1);
    n_reset = 1'b0;
    #1;
    chk("abort:s_valid", {28'b0, bus.s_valid}, 32'h0);
    chk("abort:m_ready", {31'b0, bus.m_ready}, 32'd0);
    chk("abort:bus_err", {31'b0, bus_err}, 32'd0);
    chk("abort:err_addr", err_addr, 32'h0);
    bus.m_valid = 1'b0;
    @(negedge clk_cpu);
    n_reset     = 1'b1;
    wait_cfg[0] = 0;
    data_cfg[0] = 32'h0BAD_C0DE;
    run_txn("rd_after_rst", 32'h0000_0004, 32'h0, 4'b0000, 1'b0, 1'b0, 2, 4'b0001, 1, 32'h0BAD_C0DE);

    // Overlapping windows resolve to slave 0
    ovl_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
